mole_picker: RTL and testbench
==============================

# mole_picker

Pseudo-random target generator for the whack-a-mole PRNG experiment. A free-running 16-bit Galois LFSR drives a show/gap state machine that produces one 3-bit hole index (0–7) per round. The index is held stable for a programmable window, ends early on a player hit, and feeds the downstream 7-segment decoder. A registered valid qualifier lets the top level blank the display between rounds.

## Interface
- `SEED`, 16'hACE1, LFSR reset value; 16'h0000 is replaced by 16'h0001
- `SHOW_CYCLES`, 24'd6_000_000, clock cycles a digit stays shown (>=1)
- `GAP_CYCLES`, 24'd3_000_000, clock cycles of blank between rounds (>=1)
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  game running; low forces IDLE
- `hit`  in  1  player strike, synchronous single-cycle pulse (debounced upstream)
- `digit`  out  3  current hole index to decoder, registered
- `digit_valid`  out  1  high while a round is showing
- `hit_ok`  out  1  one-cycle pulse: hit landed during SHOW
- `miss`  out  1  one-cycle pulse: SHOW window expired without hit

## Operation
- LFSR: taps polynomial x^16+x^14+x^13+x^11 (mask 16'hB400). Advances every cycle regardless of state or `en`, so hit timing adds entropy. If the state is ever all-zero, it reloads with the effective seed on the next edge.
- Candidate = `lfsr[2:0]`. If the candidate equals the current `digit`, the pick is candidate+1 mod 8 (7 wraps to 0). Two consecutive rounds never show the same index.
- FSM states and transitions:
  - IDLE: `en`=1 -> GAP with cnt=0.
  - GAP: at cnt==GAP_CYCLES-1 -> SHOW with cnt=0, `digit` loaded with the pick, `digit_valid` set to 1. Otherwise cnt+1. `hit` is ignored.
  - SHOW: if `hit` -> GAP with cnt=0, `digit_valid`<=0, `hit_ok`<=1. Otherwise, at cnt==SHOW_CYCLES-1 -> GAP with cnt=0, `digit_valid`<=0, `miss`<=1. Otherwise cnt+1.
- `en` low in any state: on the next edge go to IDLE, cnt=0, `digit_valid`=0, no pulse. This overrides `hit` and expiry on the same edge. `digit` holds its last value.
- A hit on the same edge as SHOW expiry counts as a hit: `hit_ok`=1, `miss`=0.
- One counter is shared by GAP and SHOW. Its width is $clog2 of the larger of SHOW_CYCLES and GAP_CYCLES, plus 1. It never wraps.

## Timing
- Reset values: `digit`=0, `digit_valid`=0, `hit_ok`=0, `miss`=0, state IDLE, cnt=0, lfsr=effective seed.
- All outputs are registered. No combinational path from any input to any output.
- First edge with `en` sampled high: IDLE->GAP. `digit_valid` rises GAP_CYCLES edges later.
- `digit_valid` stays high for exactly SHOW_CYCLES cycles when no hit arrives. With a hit, it falls on the edge that samples `hit`.
- `digit` changes only on the GAP->SHOW edge. It is stable for the whole time `digit_valid` is high.
- `hit_ok` and `miss` are exactly one cycle wide and mutually exclusive.
- Round period without hits = GAP_CYCLES + SHOW_CYCLES.

## Structure
- Shared package `prng_pkg`:
  - state encoding localparams: IDLE=2'd0, GAP=2'd1, SHOW=2'd2
  - `LFSR_TAPS`=16'hB400
  - `LFSR_SAFE_SEED`=16'h0001
- Sub-module `lfsr16`: clk, rst, SEED parameter, 16-bit state output, all-zero recovery. It is reused by other PRNG experiments.
- `mole_picker` contains the FSM, counter, repeat-avoid adjust and output registers.

## Test plan
Bench parameters: SEED=16'hACE1, SHOW=4, GAP=2.
1. Reset asserted mid-SHOW -> all outputs 0 at once (asynchronous); lfsr=16'hACE1; state IDLE.
2. `en`=1 sampled at edge 0, no hits -> `digit_valid`=1 after edge 2, high for 4 cycles, `miss` pulses once after edge 6, next rise after edge 8.
3. `hit` in the 2nd SHOW cycle -> `digit_valid` falls and `hit_ok`=1 on that edge, `miss` never fires; `hit` during GAP -> no pulse, timing unchanged.
4. `hit` coincident with the SHOW expiry edge -> `hit_ok`=1, `miss`=0.
5. 2000 free-running rounds -> consecutive `digit` values always differ; all 8 indices appear; `digit` matches the C reference LFSR model each round.
6. `en` dropped mid-SHOW -> IDLE next edge, `digit_valid`=0, no pulse, `digit` unchanged. SEED=0 build -> lfsr starts at 16'h0001 and never reaches zero.

Source files
------------

// File: rtl/prng_pkg.sv
// prng_pkg -- definitions shared by the PRNG experiment blocks.
//   State encodings for the show/gap round sequencer, the Galois LFSR tap
//   mask, the replacement for an all-zero seed, and the LFSR step function.
package prng_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GAP  = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_GAP  = GAP,
    ST_SHOW = SHOW
  } pick_state_e;

  // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_SAFE_SEED = 16'h0001;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16 -- free-running 16-bit Galois LFSR with all-zero recovery.
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset (loads the effective seed)
//   o_state  out  current 16-bit LFSR state
// A zero SEED is replaced by LFSR_SAFE_SEED. Should the state ever become
// all-zero (it cannot by stepping, only by upset), the next edge reloads it.
module lfsr16
  import prng_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_state
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_SAFE_SEED : SEED;

  logic [15:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED_EFF;
    end else if (r_state == 16'h0000) begin
      r_state <= SEED_EFF;
    end else begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/mole_picker.sv
// mole_picker -- whack-a-mole target generator.
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   en           in   game running; low forces IDLE
//   hit          in   single-cycle player strike
//   digit        out  hole index shown this round (registered)
//   digit_valid  out  high while a round is showing
//   hit_ok       out  one-cycle pulse: hit landed during SHOW
//   miss         out  one-cycle pulse: SHOW window expired without a hit
//
// state | meaning
// IDLE  | game stopped, display blank
// GAP   | blank interval between rounds, counting GAP_CYCLES
// SHOW  | digit shown, counting SHOW_CYCLES or until a hit
module mole_picker
  import prng_pkg::*;
#(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [23:0] SHOW_CYCLES = 24'd6_000_000,
  parameter logic [23:0] GAP_CYCLES  = 24'd3_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hit,
  output logic [2:0] digit,
  output logic       digit_valid,
  output logic       hit_ok,
  output logic       miss
);

  localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > GAP_CYCLES) ?
                                       int'(SHOW_CYCLES) : int'(GAP_CYCLES);
  localparam int unsigned CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 24'd1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 24'd1);

  pick_state_e   r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_digit, w_digit_nx;
  logic          r_valid, w_valid_nx;
  logic          r_hit_ok, w_hit_ok_nx;
  logic          r_miss, w_miss_nx;

  logic [15:0] w_lfsr;
  logic [2:0]  w_cand;
  logic [2:0]  w_pick;
  logic        w_unused_lfsr;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .o_state (w_lfsr)
  );

  // Only the low three bits choose a hole; the rest just keep the sequence long.
  assign w_unused_lfsr = ^w_lfsr[15:3];
  assign w_cand        = w_lfsr[2:0];
  // Bump a repeat of the current digit to the next hole (3-bit add wraps 7->0).
  assign w_pick        = (w_cand == r_digit) ? (w_cand + 3'd1) : w_cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_digit  <= 3'd0;
      r_valid  <= 1'b0;
      r_hit_ok <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_digit  <= w_digit_nx;
      r_valid  <= w_valid_nx;
      r_hit_ok <= w_hit_ok_nx;
      r_miss   <= w_miss_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_digit_nx  = r_digit;
    w_valid_nx  = r_valid;
    w_hit_ok_nx = 1'b0;
    w_miss_nx   = 1'b0;

    if (!en) begin
      // Stopping the game beats a hit or expiry on the same edge; digit holds.
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
      w_valid_nx = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_GAP;
          w_cnt_nx   = '0;
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_state_nx = ST_SHOW;
            w_cnt_nx   = '0;
            w_digit_nx = w_pick;
            w_valid_nx = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        ST_SHOW: begin
          // Hit is tested first so a hit on the expiry edge still scores.
          if (hit) begin
            w_state_nx  = ST_GAP;
            w_cnt_nx    = '0;
            w_valid_nx  = 1'b0;
            w_hit_ok_nx = 1'b1;
          end else if (r_cnt == SHOW_LAST) begin
            w_state_nx = ST_GAP;
            w_cnt_nx   = '0;
            w_valid_nx = 1'b0;
            w_miss_nx  = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
          w_valid_nx = 1'b0;
        end
      endcase
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_valid;
  assign hit_ok      = r_hit_ok;
  assign miss        = r_miss;

endmodule

// File: tb/tb_mole_picker.sv
// tb_mole_picker -- scoreboard bench for mole_picker (SHOW=4, GAP=2).
module tb_mole_picker;
  import prng_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [23:0] SHOW_N = 24'd4;
  localparam logic [23:0] GAP_N  = 24'd2;
  localparam int SHOW_I = 4;
  localparam int GAP_I  = 2;

  localparam int K_SHOW = 0;
  localparam int K_HIT  = 1;
  localparam int K_MISS = 2;

  typedef struct {
    int kind;
    int edge_n;
    int dig;
  } ev_t;

  ev_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       hit = 1'b0;
  logic [2:0] digit;
  logic       digit_valid, hit_ok, miss;

  logic       en0  = 1'b0;
  logic       hit0 = 1'b0;
  logic [2:0] z_digit;
  logic       z_valid, z_hit_ok, z_miss;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  mole_picker #(.SEED(SEED), .SHOW_CYCLES(SHOW_N), .GAP_CYCLES(GAP_N)) dut (
    .clk(clk), .rst(rst), .en(en), .hit(hit),
    .digit(digit), .digit_valid(digit_valid), .hit_ok(hit_ok), .miss(miss)
  );

  mole_picker #(.SEED(16'h0000), .SHOW_CYCLES(SHOW_N), .GAP_CYCLES(GAP_N)) dz (
    .clk(clk), .rst(rst), .en(en0), .hit(hit0),
    .digit(z_digit), .digit_valid(z_valid), .hit_ok(z_hit_ok), .miss(z_miss)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic pop_check(input int kind);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.edge_n != cyc || (kind == K_SHOW && e.dig != int'(digit))) begin
        n_bad++;
        $display("FAIL event: got kind %0d edge %0d digit %0d expected kind %0d edge %0d digit %0d",
                 kind, cyc, digit, e.kind, e.edge_n, e.dig);
      end
    end
  endtask

  // Monitor: observes DUT outputs and checks against the scoreboard queue.
  logic       pv;
  logic [2:0] held;
  logic [7:0] seen = 8'h00;
  int         last_dig;
  int         zero_seen = 0;

  initial begin
    pv = 1'b0;
    held = 3'd0;
    last_dig = -1;
    forever begin
      @(negedge clk);
      if (z_valid === 1'b0 && dz.w_lfsr == 16'h0000) zero_seen++;
      if (rst) begin
        pv = 1'b0;
        last_dig = -1;
        continue;
      end
      if (hit_ok || miss) chk("pulse_exclusive", int'(hit_ok & miss), 0);
      if (digit_valid && !pv) begin
        pop_check(K_SHOW);
        if (last_dig >= 0) begin
          n_cmp++;
          if (int'(digit) == last_dig) begin
            n_bad++;
            $display("FAIL repeat_digit: got %0d expected different from %0d", digit, last_dig);
          end
        end
        last_dig = int'(digit);
        seen[digit] = 1'b1;
        held = digit;
      end else if (digit_valid && pv) begin
        chk("digit_stable", int'(digit), int'(held));
      end
      if (hit_ok) begin
        pop_check(K_HIT);
        chk("valid_low_on_hit", int'(digit_valid), 0);
      end
      if (miss) pop_check(K_MISS);
      pv = digit_valid;
    end
  end

  // Reference LFSR model and round scheduler.
  logic [15:0] m_lfsr;
  int m_n;
  int prev_dig;
  int t;

  function automatic logic [15:0] ref_step(input logic [15:0] x);
    if (x == 16'h0000) return SEED;
    if (x[0]) return (x >> 1) ^ 16'hB400;
    return x >> 1;
  endfunction

  // LFSR value present just before edge r (r-1 steps after reset).
  task automatic lfsr_before(input int r, output logic [15:0] v);
    while (m_n < r - 1) begin
      m_lfsr = ref_step(m_lfsr);
      m_n++;
    end
    v = m_lfsr;
  endtask

  task automatic expect_show(input int r);
    logic [15:0] v;
    int cand, d;
    ev_t e;
    lfsr_before(r, v);
    cand = int'(v & 16'h0007);
    d = (cand == prev_dig) ? (cand + 1) % 8 : cand;
    e.kind = K_SHOW; e.edge_n = r; e.dig = d;
    exp_q.push_back(e);
    prev_dig = d;
  endtask

  // One round starting at edge t (GAP entered). hit_off>0: hit sampled at rise+hit_off.
  task automatic round(input int hit_off, input bit gap_hit);
    int r, e_end;
    ev_t e;
    r = t + GAP_I;
    expect_show(r);
    e_end = (hit_off > 0) ? r + hit_off : r + SHOW_I;
    e.kind = (hit_off > 0) ? K_HIT : K_MISS; e.edge_n = e_end; e.dig = 0;
    exp_q.push_back(e);
    for (int k = t + 1; k <= e_end; k++) begin
      hit = ((hit_off > 0) && (k == r + hit_off)) || (gap_hit && (k == t + 1));
      @(negedge clk);
    end
    hit = 1'b0;
    t = e_end;
  endtask

  task automatic start_game();
    en = 1'b1;
    @(negedge clk);
    t = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    hit = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED;
    m_n = 0;
    prev_dig = 0;
  endtask

  task automatic run_to_rise(output int r);
    r = t + GAP_I;
    expect_show(r);
    for (int k = t + 1; k <= r; k++) @(negedge clk);
  endtask

  initial begin
    int r;
    #12;
    do_reset();
    chk("rst_digit", int'(digit), 0);
    chk("rst_valid", int'(digit_valid), 0);
    chk("rst_hit_ok", int'(hit_ok), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_lfsr", int'(dut.w_lfsr), 16'hACE1);
    chk("rst_state", int'(dut.r_state), int'(IDLE));
    chk("seed0_lfsr", int'(dz.w_lfsr), 16'h0001);

    start_game();
    round(0, 1'b0);
    round(0, 1'b0);
    round(2, 1'b1);
    round(SHOW_I, 1'b0);

    // en dropped in the middle of SHOW
    run_to_rise(r);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("endrop_valid", int'(digit_valid), 0);
    chk("endrop_digit", int'(digit), prev_dig);
    chk("endrop_state", int'(dut.r_state), int'(IDLE));
    @(negedge clk);
    chk("endrop_hold_digit", int'(digit), prev_dig);
    start_game();
    round(0, 1'b0);

    // asynchronous reset in the middle of SHOW
    run_to_rise(r);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_digit", int'(digit), 0);
    chk("arst_valid", int'(digit_valid), 0);
    chk("arst_hit_ok", int'(hit_ok), 0);
    chk("arst_miss", int'(miss), 0);
    chk("arst_lfsr", int'(dut.w_lfsr), 16'hACE1);
    chk("arst_state", int'(dut.r_state), int'(IDLE));
    do_reset();
    start_game();

    repeat (2000) round(0, 1'b0);
    en = 1'b0;
    repeat (3) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    chk("all_indices", int'(seen), 8'hFF);
    chk("seed0_never_zero", zero_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
